alu_exec_stage: RTL and testbench

- Execute-stage sequencer directly upstream of the 8-bit ALU.
- Accepts one decoded ALU operation at a time over a valid/ready handshake and registers its operands and mode.
- Drives the ALU for one cycle, then captures result and flags.
- Presents the result to register-file writeback over a second valid/ready handshake, keeps the architectural flags register, and evaluates branch conditions from it.

---
 rtl/alu_pkg.sv | 66 ++++++
 rtl/alu_exec_stage_if.sv | 31 +++
 rtl/cond_eval.sv | 25 ++
 rtl/alu_exec_stage.sv | 95 +++++++++
 tb/tb_alu_exec_stage.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the execute stage: ALU op codes, flag indices,
// branch condition selects and op classification helpers.
package alu_pkg;

  localparam int FLAG_Z = 7;
  localparam int FLAG_S = 6;
  localparam int FLAG_C = 5;
  localparam int FLAG_O = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_MOV  = 4'd1,
    OP_CMP  = 4'd2,
    OP_TEST = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ADD  = 4'd6,
    OP_ADC  = 4'd7,
    OP_SUB  = 4'd8,
    OP_SBB  = 4'd9,
    OP_MUL  = 4'd10,
    OP_AND  = 4'd11,
    OP_OR   = 4'd12,
    OP_XOR  = 4'd13,
    OP_NOT  = 4'd14,
    OP_CLRF = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    CC_ALWAYS = 3'd0,
    CC_Z      = 3'd1,
    CC_NZ     = 3'd2,
    CC_C      = 3'd3,
    CC_NC     = 3'd4,
    CC_S      = 3'd5,
    CC_O      = 3'd6,
    CC_GT     = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } exec_state_e;

  function automatic logic op_writes_back(alu_op_e op);
    logic r;
    case (op)
      OP_NOP, OP_CMP,
      OP_TEST, OP_CLRF: r = 1'b0;
      default:          r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic op_updates_flags(alu_op_e op);
    logic r;
    case (op)
      OP_NOP, OP_MOV,
      OP_NOT:  r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Decoder-side issue handshake and register-file writeback handshake
// of the execute stage.
interface alu_exec_stage_if #(
  parameter int WORD_SIZE  = 8,
  parameter int REG_ADDR_W = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_op;
  logic [WORD_SIZE-1:0]  in_a;
  logic [WORD_SIZE-1:0]  in_b;
  logic [REG_ADDR_W-1:0] in_dest;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic [WORD_SIZE-1:0]  wb_data;

  modport master (
    output in_valid, in_op, in_a, in_b, in_dest,
    output wb_ready,
    input  in_ready,
    input  wb_valid, wb_dest, wb_data
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_dest,
    input  wb_ready,
    output in_ready,
    output wb_valid, wb_dest, wb_data
  );
endinterface

// File: rtl/cond_eval.sv
// Branch condition evaluator over the Z/S/C/O flag nibble.
// Purely combinational; shared with the branch unit.
module cond_eval
  import alu_pkg::*;
(
  input  logic [7:4] flags,
  input  logic [2:0] cond_sel,
  output logic       cond_true
);
  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond_sel))
      CC_ALWAYS: cond_true = 1'b1;
      CC_Z:      cond_true = flags[FLAG_Z];
      CC_NZ:     cond_true = !flags[FLAG_Z];
      CC_C:      cond_true = flags[FLAG_C];
      CC_NC:     cond_true = !flags[FLAG_C];
      CC_S:      cond_true = flags[FLAG_S];
      CC_O:      cond_true = flags[FLAG_O];
      CC_GT:     cond_true = !flags[FLAG_Z]
                           & !flags[FLAG_S];
      default:   cond_true = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage sequencer: issue, one ALU cycle, writeback handshake,
// plus the architectural flags register and branch condition output.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int REG_ADDR_W = 3
)(
  input  logic                 clk,
  input  logic                 reset_n,
  alu_exec_stage_if.slave      bus,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [3:0]           alu_mode,
  input  logic [WORD_SIZE-1:0] alu_c,
  input  logic [7:0]           alu_flags,
  output logic [7:0]           flags_q,
  input  logic [2:0]           cond_sel,
  output logic                 cond_true,
  output logic                 busy
);
  exec_state_e           r_state, w_state_nxt;
  alu_op_e               r_op;
  logic [WORD_SIZE-1:0]  r_a, r_b, r_data;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [7:0]            r_flags, w_flags_nxt;
  logic                  w_unused;

  assign w_unused = &alu_flags[3:0];

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      r_state == ST_IDLE:
        if (bus.in_valid) w_state_nxt = ST_EXEC;
      r_state == ST_EXEC:
        w_state_nxt = op_writes_back(r_op)
                    ? ST_RESP : ST_IDLE;
      r_state == ST_RESP:
        if (bus.wb_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Multiply reports only Z/S; carry and overflow stay architectural.
  always_comb begin
    w_flags_nxt = r_flags;
    if (r_op == OP_CLRF)
      w_flags_nxt = '0;
    else if (op_updates_flags(r_op))
      w_flags_nxt = {alu_flags[7:4], 4'b0};
    if (r_op == OP_MUL)
      w_flags_nxt[5:4] = r_flags[5:4];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
      r_a     <= '0;
      r_b     <= '0;
      r_dest  <= '0;
      r_data  <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && bus.in_valid) begin
        r_op   <= alu_op_e'(bus.in_op);
        r_a    <= bus.in_a;
        r_b    <= bus.in_b;
        r_dest <= bus.in_dest;
      end
      if (r_state == ST_EXEC) begin
        r_data  <= alu_c;
        r_flags <= w_flags_nxt;
      end
    end
  end

  assign bus.in_ready = (r_state == ST_IDLE);
  assign bus.wb_valid = (r_state == ST_RESP);
  assign bus.wb_dest  = r_dest;
  assign bus.wb_data  = r_data;
  assign busy         = (r_state != ST_IDLE);
  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign alu_mode     = (r_state == ST_EXEC) ? r_op : OP_NOP;
  assign flags_q      = r_flags;

  cond_eval u_cond (
    .flags     (r_flags[7:4]),
    .cond_sel  (cond_sel),
    .cond_true (cond_true)
  );
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage; the bench plays the ALU by
// driving alu_c/alu_flags with hand-computed responses per step.
module tb_alu_exec_stage;
  logic       clk;
  logic       reset_n;
  logic [7:0] alu_a, alu_b, alu_c, alu_flags, flags_q;
  logic [3:0] alu_mode;
  logic [2:0] cond_sel;
  logic       cond_true, busy;
  int         n_checks = 0;
  int         n_err    = 0;

  alu_exec_stage_if #(.WORD_SIZE(8), .REG_ADDR_W(3)) bus ();

  alu_exec_stage #(.WORD_SIZE(8), .REG_ADDR_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_mode  (alu_mode),
    .alu_c     (alu_c),
    .alu_flags (alu_flags),
    .flags_q   (flags_q),
    .cond_sel  (cond_sel),
    .cond_true (cond_true),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(logic [3:0] op, logic [7:0] a, logic [7:0] b,
                       logic [2:0] d, logic [7:0] c, logic [7:0] f);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_dest  = d;
    alu_c        = c;
    alu_flags    = f;
  endtask

  task automatic cc(logic [2:0] sel, logic exp, string tag);
    cond_sel = sel;
    #1;
    chk(tag, {7'b0, cond_true}, {7'b0, exp});
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op    = 4'd0;
    bus.in_a     = 8'h00;
    bus.in_b     = 8'h00;
    bus.in_dest  = 3'd0;
    bus.wb_ready = 1'b0;
    alu_c        = 8'h00;
    alu_flags    = 8'h00;
    cond_sel     = 3'd0;
    tick();
    tick();
    chk("rst_in_ready", {7'b0, bus.in_ready}, 8'h01);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_wb_valid", {7'b0, bus.wb_valid}, 8'h00);
    chk("rst_flags", flags_q, 8'h00);
    chk("rst_mode", {4'b0, alu_mode}, 8'h00);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_wb_data", bus.wb_data, 8'h00);
    reset_n = 1'b1;
    tick();

    // 1: add 0x7F + 0x01 -> 0x80, S and O; low flag bits must be masked
    bus.wb_ready = 1'b1;
    issue(4'd6, 8'h7F, 8'h01, 3'd3, 8'h80, 8'h5A);
    tick();
    bus.in_valid = 1'b0;
    chk("t1_exec_ready", {7'b0, bus.in_ready}, 8'h00);
    chk("t1_exec_mode", {4'b0, alu_mode}, 8'h06);
    chk("t1_exec_a", alu_a, 8'h7F);
    chk("t1_exec_b", alu_b, 8'h01);
    chk("t1_exec_wbv", {7'b0, bus.wb_valid}, 8'h00);
    tick();
    chk("t1_wb_valid", {7'b0, bus.wb_valid}, 8'h01);
    chk("t1_wb_data", bus.wb_data, 8'h80);
    chk("t1_wb_dest", {5'b0, bus.wb_dest}, 8'h03);
    chk("t1_flags", flags_q, 8'h50);
    chk("t1_resp_ready", {7'b0, bus.in_ready}, 8'h00);
    chk("t1_resp_mode", {4'b0, alu_mode}, 8'h00);
    chk("t1_hold_a", alu_a, 8'h7F);
    cc(3'd6, 1'b1, "t1_cc_o");
    tick();
    chk("t1_idle_wbv", {7'b0, bus.wb_valid}, 8'h00);
    chk("t1_idle_ready", {7'b0, bus.in_ready}, 8'h01);

    // 2: cmp 5,5 sets Z, no writeback
    issue(4'd2, 8'h05, 8'h05, 3'd1, 8'h00, 8'h80);
    tick();
    bus.in_valid = 1'b0;
    chk("t2_exec_mode", {4'b0, alu_mode}, 8'h02);
    chk("t2_exec_busy", {7'b0, busy}, 8'h01);
    tick();
    chk("t2_no_wbv", {7'b0, bus.wb_valid}, 8'h00);
    chk("t2_idle", {7'b0, bus.in_ready}, 8'h01);
    chk("t2_flags", flags_q, 8'h80);
    cc(3'd1, 1'b1, "t2_cc_z");
    cc(3'd2, 1'b0, "t2_cc_nz");

    // 3: xor with 5-cycle writeback stall; next op held on in_valid
    bus.wb_ready = 1'b0;
    issue(4'd13, 8'hAA, 8'h55, 3'd4, 8'hFF, 8'h40);
    tick();
    issue(4'd1, 8'h11, 8'h00, 3'd5, 8'hFF, 8'h40);
    alu_c = 8'hFF;
    tick();
    alu_c = 8'h11;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_wbv", {7'b0, bus.wb_valid}, 8'h01);
      chk("t3_stall_data", bus.wb_data, 8'hFF);
      chk("t3_stall_dest", {5'b0, bus.wb_dest}, 8'h04);
      chk("t3_stall_ready", {7'b0, bus.in_ready}, 8'h00);
      chk("t3_stall_a", alu_a, 8'hAA);
      tick();
    end
    chk("t3_flags", flags_q, 8'h40);
    bus.wb_ready = 1'b1;
    tick();
    chk("t3_done_wbv", {7'b0, bus.wb_valid}, 8'h00);
    chk("t3_done_ready", {7'b0, bus.in_ready}, 8'h01);
    tick();
    bus.in_valid = 1'b0;
    chk("t3_mov_mode", {4'b0, alu_mode}, 8'h01);
    chk("t3_mov_a", alu_a, 8'h11);
    tick();
    chk("t3_mov_data", bus.wb_data, 8'h11);
    chk("t3_mov_dest", {5'b0, bus.wb_dest}, 8'h05);
    chk("t3_mov_flags", flags_q, 8'h40);
    tick();

    // 4: sub 0-1 sets S,C; then clrflags zeroes regardless of ALU flags
    issue(4'd8, 8'h00, 8'h01, 3'd2, 8'hFF, 8'h60);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t4_sub_flags", flags_q, 8'h60);
    cc(3'd3, 1'b1, "t4_cc_c");
    tick();
    issue(4'd15, 8'h00, 8'h00, 3'd0, 8'h00, 8'hF0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t4_clr_flags", flags_q, 8'h00);
    chk("t4_clr_wbv", {7'b0, bus.wb_valid}, 8'h00);
    chk("t4_clr_ready", {7'b0, bus.in_ready}, 8'h01);
    cc(3'd3, 1'b0, "t4_cc_c0");

    // 5: reset asserted during RESP of shl
    bus.wb_ready = 1'b0;
    issue(4'd4, 8'h81, 8'h01, 3'd6, 8'h02, 8'h30);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t5_resp_wbv", {7'b0, bus.wb_valid}, 8'h01);
    chk("t5_resp_flags", flags_q, 8'h30);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_wbv", {7'b0, bus.wb_valid}, 8'h00);
    chk("t5_rst_flags", flags_q, 8'h00);
    chk("t5_rst_ready", {7'b0, bus.in_ready}, 8'h01);
    chk("t5_rst_data", bus.wb_data, 8'h00);
    tick();
    reset_n = 1'b1;
    bus.wb_ready = 1'b1;
    tick();
    chk("t5_post_wbv", {7'b0, bus.wb_valid}, 8'h00);
    tick();
    chk("t5_post_wbv2", {7'b0, bus.wb_valid}, 8'h00);
    chk("t5_post_busy", {7'b0, busy}, 8'h00);

    // 6: add sets C only, then not leaves flags untouched
    issue(4'd6, 8'hF0, 8'h20, 3'd1, 8'h10, 8'h20);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t6_add_flags", flags_q, 8'h20);
    tick();
    issue(4'd14, 8'h0F, 8'h00, 3'd7, 8'hF0, 8'hC0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t6_not_data", bus.wb_data, 8'hF0);
    chk("t6_not_dest", {5'b0, bus.wb_dest}, 8'h07);
    chk("t6_not_flags", flags_q, 8'h20);
    tick();

    // 7: mul takes Z/S from ALU, keeps C/O
    issue(4'd10, 8'h10, 8'h10, 3'd2, 8'h00, 8'h90);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t7_mul_data", bus.wb_data, 8'h00);
    chk("t7_mul_flags", flags_q, 8'hA0);
    cc(3'd0, 1'b1, "t7_cc_always");
    cc(3'd4, 1'b0, "t7_cc_nc");
    cc(3'd7, 1'b0, "t7_cc_gt");
    cc(3'd5, 1'b0, "t7_cc_s");
    tick();
    chk("t7_idle", {7'b0, bus.in_ready}, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
